acs_array: RTL and testbench
============================

// Module: acs_array
// PURPOSE
//  Parametrised add-compare-select array for the Viterbi decoder: one ACS cell per trellis state,
//  with registered path metrics, per-state valid tracking, metric normalisation and a registered
//  best-state search. Sits between the branch-metric unit and the traceback memory.
//  Consumes one symbol's branch metrics per in_valid cycle; emits one decision vector per symbol.
// PARAMETERS
//  K      3       constraint length; NUM_STATES = 2**(K-1)
//  G0     3'b111  generator polynomial, codeword bit 1 (K bits)
//  G1     3'b101  generator polynomial, codeword bit 0 (K bits)
//  BM_W   2       branch metric width
//  PM_W   8       path metric width; must exceed BM_W+2
// PORTS
//  clk        in   1               clock, rising edge
//  rst        in   1               synchronous, active-high reset
//  start      in   1               begin new frame: re-initialise metrics (overrides in_valid)
//  in_valid   in   1               bm_i holds metrics for one received symbol
//  bm_i       in   4*BM_W          metric per hypothesis codeword; bm_i[c*BM_W +: BM_W] is codeword c
//  out_valid  out  1               decisions and best-state outputs are valid this cycle
//  decision   out  NUM_STATES      per-state survivor select (0 = pred p0, 1 = pred p1)
//  best_state out  K-1             state index with the lowest valid path metric
//  best_pm    out  PM_W            lowest valid path metric
//  norm_evt   out  1               pulses in the cycle a normalisation was applied
// BEHAVIOUR
//  - Reset and start: pm[0]=0, valid[0]=1; pm[s]=0, valid[s]=0 for s!=0.
//    out_valid=0, decision=0, best_state=0, best_pm=0, norm_evt=0.
//  - Trellis: state s has predecessors p0={s[K-3:0],1'b0} and p1={s[K-3:0],1'b1}.
//    Input bit b=s[K-2]. Register value r={b,pred}.
//    Expected codeword c={^(r&G0),^(r&G1)}. Branch metric = bm_i[c].
//  - Per state: cost_x = pm[px] + bm (width PM_W+1). Selection uses the same rules as the existing ACS cell:
//    - only one predecessor valid: take it;
//    - neither valid: decision=0, state stays invalid;
//    - both valid: the lower cost wins; on a tie, decision=0.
//    valid_next[s] = valid[p0] | valid[p1].
//  - Latency: pm, valid, decision, best_*, norm_evt and out_valid update at the edge after in_valid.
//    out_valid is high exactly 1 cycle after each accepted symbol. There is no backpressure.
//  - Best-state search: minimum over valid states of the newly written metrics. On a tie, the lowest index wins.
//    It is computed combinationally from the next-state metrics and registered with them.
//  - Normalisation: if every valid candidate metric is >= 2**(PM_W-1), subtract 2**(PM_W-1)
//    from all valid metrics before registering, and assert norm_evt. best_pm reports the normalised value.
//  - Saturation: a selected cost >= 2**PM_W after normalisation clamps to all-ones. This is unreachable in legal use.
//  - start and in_valid in the same cycle: start wins, the symbol is dropped, out_valid=0 next cycle.
//  - rst mid-frame: all state returns to reset values at the next edge. Any in-flight out_valid is cancelled.
//  - With in_valid=0, all registers hold except out_valid and norm_evt, which drop to 0.
// STRUCTURE
//  - viterbi_pkg holds:
//    - NUM_STATES(K) localparam function;
//    - expected_codeword(pred,b,G0,G1) function;
//    - typedef pm_t (logic [PM_W-1:0] via parameter).
//  - Sub-module acs_cell is combinational and parametrised:
//    - inputs: two valid flags, two pm values, two bm values;
//    - outputs: selection, valid_o, cost (PM_W+1);
//    - one instance per state via generate.
//  - acs_array owns the pm/valid registers, normalise/saturate, min-tree and output registers.
// TESTING
//  All cases use K=3, G0=111, G1=101, BM_W=2, PM_W=8.
//  1. rst, then start, then one symbol with bm={00:0,01:1,10:1,11:2}:
//     - next cycle pm0=0 valid, pm2=2 valid, states 1 and 3 invalid;
//     - decision=4'b0000, best_state=0, best_pm=0, out_valid=1 for exactly 1 cycle.
//  2. Encode the bit sequence 1,0,1,1,0,0 and feed ideal metrics (bm=0 for the true codeword, 2 for its complement, 1 otherwise):
//     - best_pm=0 after every symbol;
//     - best_state follows the encoder state.
//  3. Two valid predecessors with equal cost (hand-built metrics): the decision bit is 0 and the cost equals either path.
//  4. 200 symbols with all bm=3:
//     - norm_evt fires;
//     - no pm exceeds 255;
//     - pairwise pm differences among valid states match a 16-bit reference model every cycle.
//  5. start asserted mid-frame together with in_valid:
//     - next cycle out_valid=0, pm returns to the init pattern;
//     - the following symbol behaves as in case 1.
//  6. rst held for 1 cycle mid-frame while in_valid=1: all outputs match the reset values next cycle, out_valid=0.

Source files
------------

// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared trellis helpers and types for the Viterbi decoder
package viterbi_pkg;
    localparam int PM_W_DEF = 8;
    typedef logic [PM_W_DEF-1:0] pm_t;
    function automatic int num_states(input int k);
        return 1 << (k - 1);
    endfunction
    function automatic logic [1:0] expected_codeword(input int pred, input int b, input int k,
                                                     input logic [31:0] g0, input logic [31:0] g1);
        logic [31:0] r;
        r = (32'(b) << (k - 1)) | 32'(pred);
        return {^(r & g0), ^(r & g1)};
    endfunction
endpackage

// File: rtl/acs_cell.sv
// acs_cell: combinational add-compare-select for one trellis state
module acs_cell
    import viterbi_pkg::*;
#(
    parameter int BM_W = 2,
    parameter int PM_W = 8
) (
    input  logic            valid0,
    input  logic            valid1,
    input  logic [PM_W-1:0] pm0,
    input  logic [PM_W-1:0] pm1,
    input  logic [BM_W-1:0] bm0,
    input  logic [BM_W-1:0] bm1,
    output logic            sel,
    output logic            valid_o,
    output logic [PM_W:0]   cost
);
    logic [PM_W:0] c0, c1;
    always_comb begin
        c0      = {1'b0, pm0} + (PM_W+1)'(bm0);
        c1      = {1'b0, pm1} + (PM_W+1)'(bm1);
        sel     = valid1 && (!valid0 || c1 < c0);
        valid_o = valid0 | valid1;
        cost    = sel ? c1 : c0;
    end
endmodule

// File: rtl/acs_array.sv
// acs_array: per-state ACS with registered metrics, normalisation and best-state search
module acs_array
    import viterbi_pkg::*;
#(
    parameter int             K    = 3,
    parameter logic [K-1:0]   G0   = 3'b111,
    parameter logic [K-1:0]   G1   = 3'b101,
    parameter int             BM_W = 2,
    parameter int             PM_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic [4*BM_W-1:0]       bm_i,
    output logic                    out_valid,
    output logic [(1<<(K-1))-1:0]   decision,
    output logic [K-2:0]            best_state,
    output logic [PM_W-1:0]         best_pm,
    output logic                    norm_evt
);
    localparam int NS = num_states(K);
    localparam logic [PM_W:0] HALF = (PM_W+1)'(1) << (PM_W - 1);

    logic [NS-1:0][PM_W-1:0] pm, pm_n;
    logic [NS-1:0][PM_W:0]   cost;
    logic [NS-1:0]           valid, valid_n, sel;
    logic [PM_W:0]           adj;
    logic [PM_W-1:0]         bpm_n;
    logic [K-2:0]            bs_n;
    logic                    all_hi, norm, found;

    for (genvar s = 0; s < NS; s++) begin : g_cell
        localparam int P0 = (2 * s) % NS;
        localparam int P1 = P0 + 1;
        localparam int B  = s >> (K - 2);
        localparam logic [1:0] C0 = expected_codeword(P0, B, K, 32'(G0), 32'(G1));
        localparam logic [1:0] C1 = expected_codeword(P1, B, K, 32'(G0), 32'(G1));
        acs_cell #(.BM_W(BM_W), .PM_W(PM_W)) u_cell (
            .valid0 (valid[P0]),
            .valid1 (valid[P1]),
            .pm0    (pm[P0]),
            .pm1    (pm[P1]),
            .bm0    (bm_i[int'(C0)*BM_W +: BM_W]),
            .bm1    (bm_i[int'(C1)*BM_W +: BM_W]),
            .sel    (sel[s]),
            .valid_o(valid_n[s]),
            .cost   (cost[s])
        );
    end

    always_comb begin
        all_hi = 1'b1;
        adj    = '0;
        pm_n   = '0;
        bs_n   = '0;
        bpm_n  = '0;
        found  = 1'b0;
        for (int s = 0; s < NS; s++)
            if (valid_n[s] && cost[s] < HALF) all_hi = 1'b0;
        norm = all_hi && |valid_n;
        for (int s = 0; s < NS; s++) begin
            adj     = norm ? cost[s] - HALF : cost[s];
            pm_n[s] = !valid_n[s] ? '0 : adj[PM_W] ? '1 : adj[PM_W-1:0];
        end
        for (int s = 0; s < NS; s++)
            if (valid_n[s] && (!found || pm_n[s] < bpm_n)) begin
                found = 1'b1;
                bs_n  = (K-1)'(s);
                bpm_n = pm_n[s];
            end
    end

    always_ff @(posedge clk) begin
        if (rst || start) begin
            pm         <= '0;
            valid      <= NS'(1);
            out_valid  <= 1'b0;
            decision   <= '0;
            best_state <= '0;
            best_pm    <= '0;
            norm_evt   <= 1'b0;
        end else if (in_valid) begin
            pm         <= pm_n;
            valid      <= valid_n;
            out_valid  <= 1'b1;
            decision   <= sel;
            best_state <= bs_n;
            best_pm    <= bpm_n;
            norm_evt   <= norm;
        end else begin
            out_valid  <= 1'b0;
            norm_evt   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_acs_array.sv
// tb_acs_array: self-checking bench for acs_array (K=3, G0=111, G1=101, BM_W=2, PM_W=8)
module tb_acs_array;
    logic       clk = 1'b0;
    logic       rst, start, in_valid;
    logic [7:0] bm_i;
    logic       out_valid, norm_evt;
    logic [3:0] decision;
    logic [1:0] best_state;
    logic [7:0] best_pm;

    int pass_cnt = 0;
    int total    = 0;
    int m[4], raw[4];
    bit v[4];
    logic [3:0] e_dec;
    int e_bs, e_bpm;
    bit e_norm;
    int norm_seen;

    typedef struct {
        logic [1:0] cw;
        logic [1:0] st;
    } vec_t;
    vec_t tbl[6];

    acs_array #(.K(3), .G0(3'b111), .G1(3'b101), .BM_W(2), .PM_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .bm_i(bm_i),
        .out_valid(out_valid), .decision(decision), .best_state(best_state),
        .best_pm(best_pm), .norm_evt(norm_evt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    endtask

    task automatic model_init();
        for (int s = 0; s < 4; s++) begin
            m[s] = 0; raw[s] = 0; v[s] = (s == 0);
        end
    endtask

    // forward expansion: every valid state tries both input bits
    task automatic model_step(input logic [7:0] bm);
        int nm[4], nr[4];
        bit nv[4];
        bit any;
        int ns, r, c, b;
        for (int s = 0; s < 4; s++) begin nm[s] = 0; nr[s] = 0; nv[s] = 0; end
        e_dec = 4'b0;
        for (int ps = 0; ps < 4; ps++)
            for (int x = 0; x < 2; x++)
                if (v[ps]) begin
                    ns = (x << 1) | (ps >> 1);
                    r  = (x << 2) | ps;
                    c  = (($countones(r & 7) % 2) << 1) | ($countones(r & 5) % 2);
                    b  = int'(bm[c*2 +: 2]);
                    if (!nv[ns] || m[ps] + b < nm[ns]) begin
                        nm[ns] = m[ps] + b;
                        nr[ns] = raw[ps] + b;
                        nv[ns] = 1;
                        e_dec[ns] = 1'(ps % 2);
                    end
                end
        e_norm = 1; any = 0;
        for (int s = 0; s < 4; s++)
            if (nv[s]) begin any = 1; if (nm[s] < 128) e_norm = 0; end
        e_norm = e_norm & any;
        e_bs = 0; e_bpm = -1;
        for (int s = 0; s < 4; s++) begin
            v[s]   = nv[s];
            raw[s] = nr[s];
            m[s]   = !nv[s] ? 0 : e_norm ? nm[s] - 128 : nm[s];
            if (nv[s] && (e_bpm < 0 || m[s] < e_bpm)) begin e_bs = s; e_bpm = m[s]; end
        end
    endtask

    task automatic check_state(input string tag);
        for (int s = 0; s < 4; s++) begin
            chk({tag, "_valid"}, int'(dut.valid[s]), int'(v[s]));
            if (v[s]) chk({tag, "_pm"}, int'(dut.pm[s]), m[s]);
        end
    endtask

    task automatic send(input logic [7:0] bm, input string tag);
        in_valid = 1'b1;
        bm_i     = bm;
        @(negedge clk);
        in_valid = 1'b0;
        model_step(bm);
        chk({tag, "_out_valid"}, int'(out_valid), 1);
        chk({tag, "_decision"}, int'(decision), int'(e_dec));
        chk({tag, "_best_state"}, int'(best_state), e_bs);
        chk({tag, "_best_pm"}, int'(best_pm), e_bpm);
        chk({tag, "_norm_evt"}, int'(norm_evt), int'(e_norm));
        check_state(tag);
    endtask

    task automatic idle(input string tag);
        @(negedge clk);
        chk({tag, "_idle_out_valid"}, int'(out_valid), 0);
        chk({tag, "_idle_norm_evt"}, int'(norm_evt), 0);
        check_state(tag);
    endtask

    task automatic check_init(input string tag);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_decision"}, int'(decision), 0);
        chk({tag, "_best_state"}, int'(best_state), 0);
        chk({tag, "_best_pm"}, int'(best_pm), 0);
        chk({tag, "_norm_evt"}, int'(norm_evt), 0);
        check_state(tag);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_init();
        check_init("start");
    endtask

    function automatic logic [7:0] ideal(input logic [1:0] cw);
        logic [7:0] bm;
        for (int c = 0; c < 4; c++)
            bm[c*2 +: 2] = (c == int'(cw)) ? 2'd0 : (c == int'(cw ^ 2'b11)) ? 2'd2 : 2'd1;
        return bm;
    endfunction

    task automatic test1_symbol(input string tag);
        send(8'b10_01_01_00, tag);
        chk({tag, "_pm0"}, int'(dut.pm[0]), 0);
        chk({tag, "_pm2"}, int'(dut.pm[2]), 2);
        chk({tag, "_valid"}, int'(dut.valid), 4'b0101);
        chk({tag, "_dec"}, int'(decision), 0);
        chk({tag, "_bs"}, int'(best_state), 0);
        chk({tag, "_bpm"}, int'(best_pm), 0);
        idle(tag);
    endtask

    initial begin
        tbl[0] = '{2'd3, 2'd2};
        tbl[1] = '{2'd2, 2'd1};
        tbl[2] = '{2'd0, 2'd2};
        tbl[3] = '{2'd1, 2'd3};
        tbl[4] = '{2'd1, 2'd1};
        tbl[5] = '{2'd3, 2'd0};
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; bm_i = 8'h00;
        model_init();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_init("reset");

        do_start();
        test1_symbol("t1");

        do_start();
        for (int i = 0; i < 6; i++) begin
            send(ideal(tbl[i].cw), "t2");
            chk("t2_enc_state", int'(best_state), int'(tbl[i].st));
            chk("t2_zero_pm", int'(best_pm), 0);
        end

        do_start();
        send(8'h00, "t3a");
        send(8'h00, "t3b");
        send(8'h00, "t3c");
        chk("t3_tie_dec", int'(decision), 0);
        for (int s = 0; s < 4; s++) chk("t3_tie_cost", int'(dut.pm[s]), 0);

        do_start();
        norm_seen = 0;
        for (int i = 0; i < 200; i++) begin
            send(8'hFF, "t4");
            if (norm_evt) norm_seen++;
            for (int s = 0; s < 4; s++)
                if (v[s]) chk("t4_diff", int'(dut.pm[s]) - int'(dut.pm[e_bs]), raw[s] - raw[e_bs]);
        end
        chk("t4_norm_seen", int'(norm_seen > 0), 1);

        send(ideal(2'd1), "t5pre");
        start = 1'b1; in_valid = 1'b1; bm_i = 8'h55;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        model_init();
        check_init("t5");
        test1_symbol("t5sym");

        send(ideal(2'd2), "t6pre");
        send(ideal(2'd0), "t6pre2");
        rst = 1'b1; in_valid = 1'b1; bm_i = 8'hA5;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        model_init();
        check_init("t6");

        do_start();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) == 0) idle("rnd");
            else send(8'($urandom), "rnd");
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
